serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer: time-shares one 1-bit full-adder/full-subtractor cell across WIDTH-bit operands, LSB first, one bit/clk.
//  Accepts an operation via valid/ready, runs WIDTH shift cycles, holds result until consumed.
//  Sits between a requesting controller and the arithmetic cell; sole owner/scheduler of that cell.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start_valid   in   1      request present; a, b, op qualified by it
//  start_ready   out  1      controller idle, request accepted when valid&ready
//  op            in   1      0 = add (a+b), 1 = subtract (a-b)
//  a             in   WIDTH  operand A (minuend)
//  b             in   WIDTH  operand B (subtrahend)
//  result_valid  out  1      res/cout/ovf valid and stable
//  result_ready  in   1      consumer takes result when valid&ready
//  res           out  WIDTH  sum or difference, modulo 2^WIDTH
//  cout          out  1      add: carry out of MSB; sub: borrow out of MSB
//  ovf           out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, start_ready=0 while rst_n low then 1 in IDLE, result_valid=0, res=0, cout=0, ovf=0, bit counter=0, carry/borrow reg=0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : start_ready=1. On valid&ready at edge k: latch a, b, op into shift regs, clear carry/borrow reg, cnt=0, go SHIFT.
//   SHIFT: start_ready=0. Each edge: cell(a_sr[0], b_sr[0], cb) -> res bit shifted in at MSB of res_sr, cb<=cell carry/borrow,
//          a_sr/b_sr shift right, cnt++. After edge k+WIDTH (cnt==WIDTH-1 processed) go DONE.
//   DONE : result_valid=1; res, cout, ovf held stable. On result_ready=1 at an edge: result_valid<=0, go IDLE.
//  Latency: result_valid rises WIDTH cycles after accept edge; min request-to-request spacing WIDTH+2 cycles (no back-to-back accept in DONE).
//  cout = final cb register value; res updated only on final SHIFT edge (no partial results visible on res).
//  start_valid while not IDLE: ignored, no state change; a/b/op changes during SHIFT have no effect.
//  result_ready while not DONE: ignored.
//  WIDTH=1: exactly one SHIFT cycle.
//  Reset asserted mid-SHIFT or in DONE: operation discarded, all outputs to reset values immediately; next request after release computes correctly.
// CONFIGURATION
//  Macro SERIAL_ADDSUB_OVF_EN:
//   defined  : ovf computed on final SHIFT edge, held in DONE.
//              add: ovf = (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1]);
//              sub: ovf = (a[W-1]!=b[W-1]) & (res[W-1]!=a[W-1]).
//   undefined: ovf tied 0, no MSB capture logic; port still present.
// STRUCTURE
//  Package serial_addsub_pkg: state enum (IDLE, SHIFT, DONE), OP_ADD=1'b0 / OP_SUB=1'b1 constants, counter width function clog2(WIDTH).
//  Sub-module addsub_bit_cell: combinational 1-bit cell, inputs x, y, cb_in, sub; outputs d, cb_out
//   (sub=0: full adder; sub=1: full subtractor, borrow = ~x&y | ~(x^y)&cb_in).
//  Top: FSM, bit counter, three WIDTH-bit shift regs, cb reg, optional ovf logic.
// TESTING (WIDTH=8 unless noted)
//  1. add a=0x3C b=0x05 -> result_valid 8 clks after accept, res=0x41 cout=0 ovf=0.
//  2. add a=0xFF b=0x01 -> res=0x00 cout=1 ovf=0; add 0x7F+0x01 -> res=0x80 cout=0 ovf=1 (macro on) / 0 (macro off).
//  3. sub a=0x05 b=0x07 -> res=0xFE cout(borrow)=1 ovf=0; sub 0x80-0x01 -> res=0x7F cout=0 ovf=1 (macro on).
//  4. hold result_ready=0 for 5 clks in DONE, toggle start_valid and a/b -> res/cout stable, start_ready=0, then accept.
//  5. rst_n low on 4th SHIFT cycle -> outputs 0 same cycle, state IDLE; after release add 0x10+0x20 -> res=0x30.
//  6. WIDTH=1: add 1+1 -> res=0 cout=1 after 1 clk; sub 0-1 -> res=1 cout=1.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Holds the FSM state enum, op encodings and the counter width helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits needed to count 0..n-1; never returns less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_cell.sv
// One-bit full adder / full subtractor shared by the serial sequencer.
// Ports: x, y, cb_in, sub in; d (sum/diff bit), cb_out (carry/borrow) out.
module addsub_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cb_in,
    input  logic sub,
    output logic d,
    output logic cb_out
);

    assign d = x ^ y ^ cb_in;

    always_comb begin
        if (sub == OP_SUB) begin
            cb_out = (~x & y) | (~(x ^ y) & cb_in);
        end else begin
            cb_out = (x & y) | ((x ^ y) & cb_in);
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer, LSB first, one bit per clock.
// Ports: clk, rst_n; start_valid/start_ready, op, a, b in; result_valid/
// result_ready, res, cout, ovf out. Macro SERIAL_ADDSUB_OVF_EN enables ovf.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, res_q;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt_q;
    logic             op_q, cb_q, cout_q;
    logic             d, cb_nx;
    logic             accept, last;

    addsub_bit_cell u_cell (
        .x      (a_sr_q[0]),
        .y      (b_sr_q[0]),
        .cb_in  (cb_q),
        .sub    (op_q),
        .d      (d),
        .cb_out (cb_nx)
    );

    assign accept = (state_q == IDLE) && start_valid;
    assign last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // New bit enters at the MSB; written width-safe so WIDTH=1 works.
    assign res_sh = (res_sr_q >> 1) | (WIDTH'(d) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid)  state_d = SHIFT;
            SHIFT:   if (last)         state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            cb_q     <= 1'b0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_sr_q <= a;
            b_sr_q <= b;
            op_q   <= op;
            cb_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == SHIFT) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= res_sh;
            cb_q     <= cb_nx;
            cnt_q    <= cnt_q + CW'(1);
            // Outputs only change on the final bit.
            if (last) begin
                res_q  <= res_sh;
                cout_q <= cb_nx;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit the shift regs hold the operand MSBs and d is res MSB.
    always_comb begin
        if (op_q == OP_SUB) begin
            ovf_d = (a_sr_q[0] != b_sr_q[0]) && (d != a_sr_q[0]);
        end else begin
            ovf_d = (a_sr_q[0] == b_sr_q[0]) && (d != a_sr_q[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign start_ready  = rst_n && (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign res          = res_q;
    assign cout         = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8 and WIDTH=1).
// Scoreboard of expected results checked when result_valid rises.
module tb_serial_addsub_ctrl;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid, start_ready, op;
    logic [7:0] a, b, res;
    logic       result_valid, result_ready, cout, ovf;

    logic       v1, rdy1, op1, a1, b1, rv1, rr1, res1, c1, o1;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .res          (res),
        .cout         (cout),
        .ovf          (ovf)
    );

    serial_addsub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (v1),
        .start_ready  (rdy1),
        .op           (op1),
        .a            (a1),
        .b            (b1),
        .result_valid (rv1),
        .result_ready (rr1),
        .res          (res1),
        .cout         (c1),
        .ovf          (o1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic, signed range test for ovf.
    function automatic exp_t model8(input logic o, input logic [7:0] x,
                                    input logic [7:0] y);
        exp_t e;
        int   u, s;
        if (o) begin
            u = int'(x) - int'(y);
            s = int'($signed(x)) - int'($signed(y));
        end else begin
            u = int'(x) + int'(y);
            s = int'($signed(x)) + int'($signed(y));
        end
        e.res  = u[7:0];
        e.cout = (u > 255) || (u < 0);
        e.ovf  = OVF_ON && ((s > 127) || (s < -128));
        return e;
    endfunction

    task automatic run_op(input logic o, input logic [7:0] x,
                          input logic [7:0] y, input int hold);
        int   lat;
        exp_t e;
        @(negedge clk);
        chk("rdy_idle", start_ready, 1);
        start_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        sb.push_back(model8(o, x, y));
        @(posedge clk); #1;
        start_valid = 1'b0;
        op = ~o;
        a  = ~x;
        b  = ~y;
        lat = 0;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 8);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            start_valid = ~start_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_vld", result_valid, 1);
            chk("hold_res", res, e.res);
            chk("hold_cout", cout, e.cout);
            chk("hold_rdy", start_ready, 0);
        end
        start_valid = 1'b0;
        chk("res", res, e.res);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("drain_vld", result_valid, 0);
        chk("drain_rdy", start_ready, 1);
    endtask

    task automatic run1(input logic o, input logic x, input logic y,
                        input logic er, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        chk("w1_rdy", rdy1, 1);
        v1  = 1'b1;
        op1 = o;
        a1  = x;
        b1  = y;
        @(posedge clk); #1;
        v1 = 1'b0;
        lat = 0;
        while (!rv1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w1_lat", lat, 1);
        chk("w1_res", res1, er);
        chk("w1_cout", c1, ec);
        chk("w1_ovf", o1, OVF_ON && eo);
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        chk("w1_drain", rv1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0; op = 1'b0; a = '0; b = '0; result_ready = 1'b0;
        v1 = 1'b0; op1 = 1'b0; a1 = 1'b0; b1 = 1'b0; rr1 = 1'b0;
        #2;
        chk("rst_rdy", start_ready, 0);
        chk("rst_vld", result_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", start_ready, 1);

        run_op(1'b0, 8'h3C, 8'h05, 0);
        run_op(1'b0, 8'hFF, 8'h01, 0);
        run_op(1'b0, 8'h7F, 8'h01, 0);
        run_op(1'b1, 8'h05, 8'h07, 0);
        run_op(1'b1, 8'h80, 8'h01, 0);
        run_op(1'b0, 8'hA5, 8'h5A, 5);

        // Reset in the 4th shift cycle aborts the operation.
        @(negedge clk);
        start_valid = 1'b1; op = 1'b0; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_vld", result_valid, 0);
        chk("abort_res", res, 0);
        chk("abort_cout", cout, 0);
        chk("abort_rdy", start_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", start_ready, 1);
        run_op(1'b0, 8'h10, 8'h20, 0);

        for (int i = 0; i < 16; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), i % 3);
        end

        run1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        run1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
